// File: rtl/mux_n_to_1_pipe_if.sv
// Handshake bundle for mux_n_to_1_pipe. Optional sel_err_o/err_clr_i appear under MUX_N_TO_1_PIPE_SELERR_EN.
interface mux_n_to_1_pipe_if #(
    parameter int SIZE   = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [SIZE*NUM_IN-1:0] data_i;
    logic [SEL_W-1:0]       select_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [SIZE-1:0]        data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [1:0]             count_o;
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
    logic                   sel_err_o;
    logic                   err_clr_i;
`endif

    // The selector block itself sits on the slave side.
    modport slave (
        input  data_i, select_i, valid_i, ready_i,
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        input  err_clr_i,
        output sel_err_o,
`endif
        output ready_o, data_o, valid_o, count_o
    );

    modport master (
        output data_i, select_i, valid_i, ready_i,
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        output err_clr_i,
        input  sel_err_o,
`endif
        input  ready_o, data_o, valid_o, count_o
    );
endinterface

// File: rtl/mux_n_to_1_pipe.sv
// N-to-1 selector feeding a 2-entry skid buffer (main M + skid S) with valid/ready on both sides.
// Define MUX_N_TO_1_PIPE_SELERR_EN to add the sticky out-of-range select flag.
module mux_n_to_1_pipe #(
    parameter int SIZE   = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    mux_n_to_1_pipe_if.slave bus
);
    logic [SIZE-1:0] sel_data;
    logic [SIZE-1:0] m_data;
    logic [SIZE-1:0] s_data;
    logic            m_valid;
    logic            s_valid;
    logic            accept;
    logic            pop;

    // Unmatched or out-of-range select falls back to input 0.
    always_comb begin
        sel_data = bus.data_i[0 +: SIZE];
        for (int k = 1; k < NUM_IN; k++) begin
            if (bus.select_i == SEL_W'(k)) begin
                sel_data = bus.data_i[k*SIZE +: SIZE];
            end
        end
    end

    assign accept = bus.valid_i & ~s_valid;
    assign pop    = m_valid & bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_data  <= '0;
            s_data  <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_valid && !pop) begin
            if (accept) begin
                s_data  <= sel_data;
                s_valid <= 1'b1;
            end
        end else if (s_valid) begin
            // S is only ever full while ready_o is low, so no accept competes here.
            m_data  <= s_data;
            s_valid <= 1'b0;
        end else if (accept) begin
            m_data  <= sel_data;
            m_valid <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    assign bus.data_o  = m_data;
    assign bus.valid_o = m_valid;
    assign bus.ready_o = ~s_valid;
    assign bus.count_o = {1'b0, m_valid} + {1'b0, s_valid};

`ifdef MUX_N_TO_1_PIPE_SELERR_EN
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
    logic sel_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel_err <= 1'b0;
        end else if (accept && ({1'b0, bus.select_i} >= NUM_IN_W)) begin
            sel_err <= 1'b1;
        end else if (bus.err_clr_i) begin
            sel_err <= 1'b0;
        end
    end

    assign bus.sel_err_o = sel_err;
`endif
endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed bench: table of vectors on a 4-input instance, hand sequences for reset and a 3-input out-of-range instance.
module tb_mux_n_to_1_pipe;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mux_n_to_1_pipe_if #(.SIZE(32), .NUM_IN(4), .SEL_W(2)) bus_a ();
    mux_n_to_1_pipe_if #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) bus_b ();

    mux_n_to_1_pipe #(.SIZE(32), .NUM_IN(4), .SEL_W(2)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .bus(bus_a)
    );
    mux_n_to_1_pipe #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        valid;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic valid, input logic rdy);
        bus_a.select_i = sel;
        bus_a.valid_i  = valid;
        bus_a.ready_i  = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyB(input logic [1:0] sel, input logic valid, input logic clr);
        bus_b.select_i = sel;
        bus_b.valid_i  = valid;
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        bus_b.err_clr_i = clr;
`else
        if (clr) begin
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        //           sel    v     r     ev    data       cnt   rdy
        vecs[0]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1, 1'b1};
        vecs[1]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'hA0, 2'd1, 1'b1};
        vecs[2]  = '{2'd1, 1'b1, 1'b1, 1'b1, 32'hA1, 2'd1, 1'b1};
        vecs[3]  = '{2'd2, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1, 1'b1};
        vecs[4]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'hA3, 2'd1, 1'b1};
        vecs[5]  = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[6]  = '{2'd1, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1};
        vecs[7]  = '{2'd3, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        vecs[8]  = '{2'd0, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        vecs[9]  = '{2'd0, 1'b0, 1'b1, 1'b1, 32'hA3, 2'd1, 1'b1};
        vecs[10] = '{2'd0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1};
        vecs[12] = '{2'd0, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd2, 1'b0};
        vecs[13] = '{2'd1, 1'b0, 1'b0, 1'b1, 32'hA2, 2'd2, 1'b0};

        rst_n          = 1'b0;
        bus_a.data_i   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        bus_a.select_i = '0;
        bus_a.valid_i  = 1'b0;
        bus_a.ready_i  = 1'b0;
        bus_b.data_i   = {32'hB2, 32'hB1, 32'hB0};
        bus_b.select_i = '0;
        bus_b.valid_i  = 1'b0;
        bus_b.ready_i  = 1'b1;
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        bus_b.err_clr_i = 1'b0;
`endif
        repeat (2) @(negedge clk);

        checkOutput("reset valid_o", {31'd0, bus_a.valid_o}, 32'd0);
        checkOutput("reset data_o",  bus_a.data_o, 32'd0);
        checkOutput("reset count_o", {30'd0, bus_a.count_o}, 32'd0);
        checkOutput("reset ready_o", {31'd0, bus_a.ready_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].valid, vecs[i].rdy);
            checkOutput($sformatf("vec%0d valid_o", i), {31'd0, bus_a.valid_o}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d data_o", i), bus_a.data_o, vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d count_o", i), {30'd0, bus_a.count_o}, {30'd0, vecs[i].exp_count});
            checkOutput($sformatf("vec%0d ready_o", i), {31'd0, bus_a.ready_o}, {31'd0, vecs[i].exp_ready});
        end

        // Asynchronous reset between edges while both entries are full.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst valid_o", {31'd0, bus_a.valid_o}, 32'd0);
        checkOutput("async rst data_o",  bus_a.data_o, 32'd0);
        checkOutput("async rst count_o", {30'd0, bus_a.count_o}, 32'd0);
        checkOutput("async rst ready_o", {31'd0, bus_a.ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.valid_i = 1'b0;
        @(negedge clk);
        checkOutput("post rst count_o", {30'd0, bus_a.count_o}, 32'd0);

`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        checkOutput("b sel_err reset", {31'd0, bus_b.sel_err_o}, 32'd0);
`endif
        applyB(2'd3, 1'b1, 1'b0);
        checkOutput("b oor valid_o", {31'd0, bus_b.valid_o}, 32'd1);
        checkOutput("b oor data_o", bus_b.data_o, 32'hB0);
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        checkOutput("b sel_err set", {31'd0, bus_b.sel_err_o}, 32'd1);
`endif
        applyB(2'd0, 1'b0, 1'b1);
        checkOutput("b drain valid_o", {31'd0, bus_b.valid_o}, 32'd0);
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        checkOutput("b sel_err clr", {31'd0, bus_b.sel_err_o}, 32'd0);
`endif
        applyB(2'd3, 1'b1, 1'b1);
        checkOutput("b oor2 data_o", bus_b.data_o, 32'hB0);
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        checkOutput("b set beats clr", {31'd0, bus_b.sel_err_o}, 32'd1);
`endif
        applyB(2'd2, 1'b1, 1'b0);
        checkOutput("b sel2 data_o", bus_b.data_o, 32'hB2);
`ifdef MUX_N_TO_1_PIPE_SELERR_EN
        checkOutput("b sel_err sticky", {31'd0, bus_b.sel_err_o}, 32'd1);
`endif
        applyB(2'd1, 1'b1, 1'b0);
        checkOutput("b sel1 data_o", bus_b.data_o, 32'hB1);
        checkOutput("b sel1 count_o", {30'd0, bus_b.count_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
